// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port-pair RAM: latches one command, runs it, answers with done.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module ram_arbiter #(
    parameter int A      = 4,
    parameter int W      = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [1:0]     req_i,
    input  logic [1:0]     we_i,
    input  logic [2*A-1:0] addr_i,
    input  logic [2*W-1:0] wdata_i,
    output logic [1:0]     gnt_o,
    output logic [1:0]     done_o,
    output logic [W-1:0]   rdata_o,
    output logic           busy_o,
    output logic           ram_we_o,
    output logic [A-1:0]   ram_waddr_o,
    output logic [A-1:0]   ram_raddr_o,
    output logic [W-1:0]   ram_wdata_o,
    input  logic [W-1:0]   ram_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t         r_state;
    state_t         w_next;
    logic           r_k;
    logic [A-1:0]   r_addr;
    logic [W-1:0]   r_wdata;
    logic [W-1:0]   r_rdata;
    logic [1:0]     r_cnt;
    logic           w_win;
    logic           w_accept;
    logic           w_rd_last;
    logic [A-1:0]   w_sel_addr;
    logic [W-1:0]   w_sel_wdata;

`ifndef RAM_ARB_FIXED_PRIO_EN
    logic           r_last;
`endif

    // Winner among the active requests; only meaningful when some req_i bit is set.
    always_comb begin
        w_win = 1'b0;
        if (req_i == 2'b10) begin
            w_win = 1'b1;
        end else if (req_i == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            w_win = 1'b0;
`else
            w_win = ~r_last;
`endif
        end
    end

    assign w_accept    = (r_state == S_IDLE) && (req_i != 2'b00) && !rst_i;
    assign w_rd_last   = (r_cnt == LAT);
    assign w_sel_addr  = w_win ? addr_i[2*A-1:A]  : addr_i[A-1:0];
    assign w_sel_wdata = w_win ? wdata_i[2*W-1:W] : wdata_i[W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        gnt_o    = 2'b00;
        done_o   = 2'b00;
        busy_o   = 1'b1;
        ram_we_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (w_accept) begin
                    gnt_o  = w_win ? 2'b10 : 2'b01;
                    w_next = we_i[w_win] ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                ram_we_o = 1'b1;
                w_next   = S_RESP;
            end
            S_READ: begin
                if (w_rd_last) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                done_o = r_k ? 2'b10 : 2'b01;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, read-latency counter and read-data capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_k     <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 2'd0;
        end else begin
            if (w_accept) begin
                r_k     <= w_win;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state == S_READ) begin
                if (w_rd_last) begin
                    r_rdata <= ram_rdata_i;
                    r_cnt   <= 2'd0;
                end else begin
                    r_cnt   <= r_cnt + 2'd1;
                end
            end
        end
    end

`ifndef RAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_win;
        end
    end
`endif

    assign rdata_o     = r_rdata;
    assign ram_waddr_o = r_addr;
    assign ram_raddr_o = r_addr;
    assign ram_wdata_o = r_wdata;

endmodule
